adder_tree: RTL and testbench

// - Pipelined signed reduction adder: sums NINPUTS signed IWIDTH-bit operands into one OWIDTH-bit result.
// - Used as the accumulation stage of the convolution datapath (e.g. 3x3x3 = 27 products per output).
// - Full throughput: accepts one input vector every cycle.

---
 rtl/adder_tree.sv | 100 ++++++++++
 tb/tb_adder_tree.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree.sv
// Pipelined signed reduction adder tree, one vector per cycle.
// Define ADDER_TREE_SAT_EN to saturate (instead of wrap) when OWIDTH < SW.
module adder_tree #(
  parameter int NINPUTS = 27,
  parameter int IWIDTH  = 8,
  parameter int OWIDTH  = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [IWIDTH-1:0] d [NINPUTS],
  output logic                     out_valid,
  output logic signed [OWIDTH-1:0] q
);

  localparam int LEVELS = (NINPUTS > 1) ? $clog2(NINPUTS) : 1;
  localparam int SW = (NINPUTS > 1) ? IWIDTH + $clog2(NINPUTS) : IWIDTH;

  function automatic int cnt(input int l);
    int n;
    n = NINPUTS;
    for (int i = 0; i < l; i++) n = (n + 1) / 2;
    return n;
  endfunction

  logic [LEVELS-1:0] vpipe;
  logic signed [SW-1:0] fin;
  logic signed [OWIDTH-1:0] res;

  genvar l, k;
  for (l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NI = cnt(l);
    localparam int NO = cnt(l + 1);
    logic signed [SW-1:0] t [NI];
    logic signed [SW-1:0] s [NO];
    logic signed [SW-1:0] o [NO];

    if (l == 0) begin : g_src
      for (k = 0; k < NI; k++) begin : g_ext
        assign t[k] = SW'(d[k]);
      end
    end else begin : g_src
      assign t = g_lvl[l-1].o;
    end

    for (k = 0; k < NO; k++) begin : g_sum
      if (2 * k + 1 < NI) begin : g_pair
        assign s[k] = t[2*k] + t[2*k+1];
      end else begin : g_odd
        assign s[k] = t[2*k];
      end
    end

    // the last level's sum feeds the q register directly
    if (l == LEVELS - 1) begin : g_last
      assign o = s;
    end else begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < NO; i++) o[i] <= '0;
        end else begin
          o <= s;
        end
      end
    end
  end

  assign fin = g_lvl[LEVELS-1].o[0];

  if (OWIDTH >= SW) begin : g_wide
    assign res = OWIDTH'(fin);
  end else begin : g_narrow
`ifdef ADDER_TREE_SAT_EN
    localparam logic signed [SW-1:0] MAXV =
      {{(SW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV =
      {{(SW-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};
    always_comb begin
      res = fin[OWIDTH-1:0];
      if (fin > MAXV) res = MAXV[OWIDTH-1:0];
      else if (fin < MINV) res = MINV[OWIDTH-1:0];
    end
`else
    assign res = fin[OWIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      vpipe <= '0;
    end else begin
      q     <= res;
      vpipe <= LEVELS'({vpipe, in_valid});
    end
  end

  assign out_valid = vpipe[LEVELS-1];

endmodule

// File: tb/tb_adder_tree.sv
// Scoreboard bench for adder_tree: default, narrow-output,
// one-input and two-input instances.
module tb_adder_tree;

  typedef struct {
    int v;
    int c;
  } exp_t;

`ifdef ADDER_TREE_SAT_EN
  localparam int E127 = 511;
  localparam int E128 = -512;
`else
  localparam int E127 = 357;
  localparam int E128 = -384;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   nvec = 0;
  int   nbad = 0;

  logic iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0, iv3 = 1'b0;
  logic ov0, ov1, ov2, ov3;
  logic signed [7:0] d0 [27];
  logic signed [7:0] d1 [27];
  logic signed [7:0] d2 [1];
  logic signed [7:0] d3 [2];
  logic signed [17:0] q0;
  logic signed [9:0]  q1;
  logic signed [17:0] q2;
  logic signed [17:0] q3;

  exp_t sb0[$], sb1[$], sb2[$], sb3[$];

  adder_tree #(.NINPUTS(27), .IWIDTH(8), .OWIDTH(18)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .d(d0),
    .out_valid(ov0), .q(q0));
  adder_tree #(.NINPUTS(27), .IWIDTH(8), .OWIDTH(10)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .d(d1),
    .out_valid(ov1), .q(q1));
  adder_tree #(.NINPUTS(1), .IWIDTH(8), .OWIDTH(18)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .d(d2),
    .out_valid(ov2), .q(q2));
  adder_tree #(.NINPUTS(2), .IWIDTH(8), .OWIDTH(18)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .d(d3),
    .out_valid(ov3), .q(q3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int gq, input int eq,
                     input int gc, input int ec);
    nvec++;
    if (gq != eq || gc != ec) begin
      nbad++;
      $display("FAIL %s: q=%0d at cycle %0d, expected q=%0d at cycle %0d",
               nm, gq, gc, eq, ec);
    end
  endtask

  task automatic unexp(input string nm, input int gq, input int gc);
    nvec++;
    nbad++;
    $display("FAIL %s: unexpected out_valid q=%0d at cycle %0d, expected none",
             nm, gq, gc);
  endtask

  task automatic chkr(input string nm, input int gq, input logic gv);
    nvec++;
    if (gq != 0 || gv !== 1'b0) begin
      nbad++;
      $display("FAIL %s: q=%0d out_valid=%0b, expected q=0 out_valid=0",
               nm, gq, gv);
    end
  endtask

  always @(negedge clk) if (ov0) begin : m0
    exp_t e;
    if (sb0.size() == 0) unexp("u0", int'(q0), cyc);
    else begin
      e = sb0.pop_front();
      chk("u0", int'(q0), e.v, cyc, e.c);
    end
  end

  always @(negedge clk) if (ov1) begin : m1
    exp_t e;
    if (sb1.size() == 0) unexp("u1", int'(q1), cyc);
    else begin
      e = sb1.pop_front();
      chk("u1", int'(q1), e.v, cyc, e.c);
    end
  end

  always @(negedge clk) if (ov2) begin : m2
    exp_t e;
    if (sb2.size() == 0) unexp("u2", int'(q2), cyc);
    else begin
      e = sb2.pop_front();
      chk("u2", int'(q2), e.v, cyc, e.c);
    end
  end

  always @(negedge clk) if (ov3) begin : m3
    exp_t e;
    if (sb3.size() == 0) unexp("u3", int'(q3), cyc);
    else begin
      e = sb3.pop_front();
      chk("u3", int'(q3), e.v, cyc, e.c);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill0(input int v);
    for (int i = 0; i < 27; i++) d0[i] = 8'(v);
  endtask

  task automatic fill1(input int v);
    for (int i = 0; i < 27; i++) d1[i] = 8'(v);
  endtask

  task automatic send0(input int v, input int e);
    fill0(v);
    iv0 = 1'b1;
    sb0.push_back('{e, cyc + 5});
  endtask

  task automatic send1(input int v, input int e);
    fill1(v);
    iv1 = 1'b1;
    sb1.push_back('{e, cyc + 5});
  endtask

  task automatic send2(input int a, input int e);
    d2[0] = 8'(a);
    iv2 = 1'b1;
    sb2.push_back('{e, cyc + 1});
  endtask

  task automatic send3(input int a, input int b, input int e);
    d3[0] = 8'(a);
    d3[1] = 8'(b);
    iv3 = 1'b1;
    sb3.push_back('{e, cyc + 1});
  endtask

  task automatic idle();
    iv0 = 1'b0;
    iv1 = 1'b0;
    iv2 = 1'b0;
    iv3 = 1'b0;
  endtask

  task automatic rst_chk();
    chkr("rst_u0", int'(q0), ov0);
    chkr("rst_u1", int'(q1), ov1);
    chkr("rst_u2", int'(q2), ov2);
    chkr("rst_u3", int'(q3), ov3);
  endtask

  initial begin
    fill0(0);
    fill1(0);
    d2[0] = '0;
    d3[0] = '0;
    d3[1] = '0;

    @(posedge clk);
    #2;
    rst_chk();
    rst_n = 1'b1;
    tick();

    send0(1, 27);
    send1(1, 27);
    send2(-5, -5);
    send3(-5, 3, -2);
    tick();
    idle();
    repeat (7) tick();

    send0(2, 54);
    send1(127, E127);
    send2(127, 127);
    send3(127, 127, 254);
    tick();
    send0(-128, -3456);
    send1(-128, E128);
    send2(-128, -128);
    send3(-128, -128, -256);
    tick();
    idle();
    send0(127, 3429);
    tick();
    for (int i = 0; i < 27; i++) d0[i] = (i % 2 == 0) ? 8'sd127 : -8'sd128;
    sb0.push_back('{114, cyc + 5});
    tick();
    iv0 = 1'b0;
    tick();
    for (int i = 0; i < 27; i++) d0[i] = 8'(i);
    sb0.push_back('{351, cyc + 5});
    iv0 = 1'b1;
    tick();
    iv0 = 1'b0;
    repeat (8) tick();

    send0(3, 81);
    tick();
    send0(-1, -27);
    tick();
    send0(4, 108);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    rst_chk();
    sb0.delete();
    sb1.delete();
    sb2.delete();
    sb3.delete();
    idle();
    tick();
    #2;
    rst_n = 1'b1;
    repeat (8) tick();

    send0(1, 27);
    tick();
    iv0 = 1'b0;
    repeat (8) tick();

    nvec++;
    if (sb0.size() + sb1.size() + sb2.size() + sb3.size() != 0) begin
      nbad++;
      $display("FAIL drain: %0d results outstanding, expected 0",
               sb0.size() + sb1.size() + sb2.size() + sb3.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
